// File: rtl/ysyx_22051086_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD fetch FSM with redirect and drop handling.
// Optional perf counters enabled by defining YSYX_22051086_IFU_PERF_EN.
module ysyx_22051086_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ic_raddr,
  output logic        ic_rwen,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rdata_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic        drop;
  logic        accept;
  logic        unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign ic_raddr    = pc;

  // A response is kept only if nothing has invalidated it.
  assign accept = (state == S_WAIT) & ic_rdata_valid
                & ~drop & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_REQ: begin
        if (!redirect_valid) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (ic_rdata_valid)
          state_nx = (redirect_valid || drop) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  always_comb begin
    ic_rwen    = 1'b0;
    inst_valid = 1'b0;
    if (!rst && !redirect_valid) begin
      ic_rwen    = (state == S_REQ);
      inst_valid = (state == S_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= 32'h0;
    end else begin
      if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
      else if (accept)    pc <= pc + 32'd4;
      if (accept) begin
        inst    <= ic_rdata;
        inst_pc <= pc;
      end
      // The outstanding response is stale once a redirect passes it.
      if (state == S_WAIT) begin
        if (ic_rdata_valid)      drop <= 1'b0;
        else if (redirect_valid) drop <= 1'b1;
      end
    end
  end

`ifdef YSYX_22051086_IFU_PERF_EN
  logic fire;
  assign fire = inst_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fire)            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == S_WAIT) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_22051086_ifu.sv
// Directed bench for ysyx_22051086_ifu: per-cycle vector table plus
// a perf-counter sequence with hit and miss latencies.
module tb_ysyx_22051086_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] ic_raddr;
  logic        ic_rwen;
  logic [31:0] ic_rdata;
  logic        ic_rdata_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  ysyx_22051086_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .ic_raddr       (ic_raddr),
    .ic_rwen        (ic_rwen),
    .ic_rdata       (ic_rdata),
    .ic_rdata_valid (ic_rdata_valid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] d;
    logic        rv;
    logic [31:0] rp;
    logic        rdy;
    logic        e_rwen;
    logic        ca;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        ci;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_fail;

  task automatic add(
    input logic rs, input logic v, input logic [31:0] d,
    input logic rv, input logic [31:0] rp, input logic rdy,
    input logic erw, input logic ca, input logic [31:0] ea,
    input logic eiv, input logic ci,
    input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t.rst = rs; t.v = v; t.d = d; t.rv = rv; t.rp = rp;
    t.rdy = rdy; t.e_rwen = erw; t.ca = ca; t.e_addr = ea;
    t.e_iv = eiv; t.ci = ci; t.e_inst = ei; t.e_ipc = ep;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic v, input logic [31:0] d,
                       input logic rv, input logic [31:0] rp,
                       input logic rdy);
    @(negedge clk);
    rst            = rs;
    ic_rdata_valid = v;
    ic_rdata       = d;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
    #1;
  endtask

  localparam logic [31:0] B = 32'h8000_0000;

  int          lat;
  logic [31:0] exp_stall;
  logic [31:0] exp_fetch;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    ic_rdata = '0;
    ic_rdata_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;

    // reset
    add(1,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(1,0,0,0,0,0, 0,1,B,     0,1,0,0);
    // hit timing, ready=1
    add(0,0,0,0,0,0, 1,1,B,     0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'hAAAA0001,0,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,     1,1,32'hAAAA0001,B);
    add(0,0,0,0,0,0, 1,1,B+4,   0,0,0,0);
    // decode stall 5 cycles in HOLD
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'hBBBB0002,0,0,0, 0,0,0, 0,0,0,0);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0,0, 0,0,0,   1,1,32'hBBBB0002,B+4);
    add(0,0,0,0,0,1, 0,0,0,     1,1,32'hBBBB0002,B+4);
    add(0,0,0,0,0,0, 1,1,B+8,   0,0,0,0);
    // redirect during WAIT drops the pending response
    add(0,0,0,1,B+32'h100,0, 0,0,0, 0,0,0,0);
    add(0,1,32'hDEAD0000,0,0,1, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 1,1,B+32'h100, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'hCCCC0003,0,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,     1,1,32'hCCCC0003,B+32'h100);
    add(0,0,0,0,0,0, 1,1,B+32'h104, 0,0,0,0);
    // redirect coincident with response, then redirect in HOLD
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'hEEEE0000,1,B+32'h300,1, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 1,1,B+32'h300, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'hDDDD0004,0,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0,1,B+32'h203,1, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 1,1,B+32'h200, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'h11110005,0,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,     1,1,32'h11110005,B+32'h200);
    // redirect in REQ suppresses request; strobes in REQ/HOLD ignored
    add(0,0,0,1,32'hFFFF_FFFC,0, 0,0,0, 0,0,0,0);
    add(0,1,32'h99,0,0,0, 1,1,32'hFFFF_FFFC, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'h22220006,0,0,0, 0,0,0, 0,0,0,0);
    add(0,1,32'h77,0,0,1, 0,0,0, 1,1,32'h22220006,32'hFFFF_FFFC);
    add(0,0,0,0,0,0, 1,1,32'h0, 0,0,0,0);
    // back-to-back redirects: last wins, one drop
    add(0,0,0,1,B+32'h400,0, 0,0,0, 0,0,0,0);
    add(0,0,0,1,B+32'h500,0, 0,0,0, 0,0,0,0);
    add(0,1,32'h55,0,0,1, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 1,1,B+32'h500, 0,0,0,0);
    // reset mid-WAIT, late strobe in REQ ignored
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'h66,0,0,0, 1,1,B, 0,1,0,0);
    add(0,0,0,0,0,0, 0,0,0,     0,0,0,0);
    add(0,1,32'h33330007,0,0,0, 0,0,0, 0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,     1,1,32'h33330007,B);
    add(0,0,0,0,0,0, 1,1,B+4,   0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d,
            tbl[i].rv, tbl[i].rp, tbl[i].rdy);
      chk("ic_rwen", i, {31'b0, ic_rwen}, {31'b0, tbl[i].e_rwen});
      chk("inst_valid", i, {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
      if (tbl[i].ca) chk("ic_raddr", i, ic_raddr, tbl[i].e_addr);
      if (tbl[i].ci) begin
        chk("inst", i, inst, tbl[i].e_inst);
        chk("inst_pc", i, inst_pc, tbl[i].e_ipc);
      end
    end

    // perf: 10 fetches, two of them with 8 extra wait cycles
    drive(1,0,0,0,0,0);
    drive(1,0,0,0,0,0);
    chk("fetch_cnt_rst", 0, perf_fetch_cnt, 32'h0);
    chk("stall_cnt_rst", 0, perf_stall_cnt, 32'h0);
    exp_stall = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0,0,0,0,0,0);
      chk("perf_rwen", k, {31'b0, ic_rwen}, 32'h1);
      chk("perf_raddr", k, ic_raddr, B + 32'(4 * k));
      lat = (k == 3 || k == 7) ? 10 : 2;
      for (int j = 0; j < lat; j++)
        drive(0, (j == lat - 1), 32'(k), 0, 0, 0);
      exp_stall = exp_stall + 32'(lat);
      drive(0,0,0,0,0,1);
      chk("perf_iv", k, {31'b0, inst_valid}, 32'h1);
      chk("perf_inst_pc", k, inst_pc, B + 32'(4 * k));
    end
    drive(0,0,0,0,0,0);
`ifdef YSYX_22051086_IFU_PERF_EN
    exp_fetch = 32'd10;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    chk("perf_fetch_cnt", 0, perf_fetch_cnt, exp_fetch);
    chk("perf_stall_cnt", 0, perf_stall_cnt, exp_stall);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22051086_ifu.md
YSYX_22051086_IFU -- requirements
Module: ysyx_22051086_ifu

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: ic_raddr  output  32  fetch address to the instruction cache.
REQ-005 Port: ic_rwen  output  1  one-cycle fetch request pulse to the instruction cache.
REQ-006 Port: ic_rdata  input  32  instruction word from the cache.
REQ-007 Port: ic_rdata_valid  input  1  single-cycle response strobe from the cache.
REQ-008 Port: redirect_valid  input  1  branch/jump/trap redirect from execute.
REQ-009 Port: redirect_pc  input  32  redirect target.
REQ-010 Port: inst_valid  output  1  instruction available to decode.
REQ-011 Port: inst_ready  input  1  decode accepts the instruction.
REQ-012 Port: inst  output  32  fetched instruction.
REQ-013 Port: inst_pc  output  32  address of inst.
REQ-014 Port: perf_fetch_cnt  output  32  delivered-instruction counter.
REQ-015 Port: perf_stall_cnt  output  32  cache-wait cycle counter.

Function
REQ-016 FSM states REQ, WAIT, HOLD; exactly one request outstanding at any time.
REQ-017 REQ: ic_rwen=1 and ic_raddr=pc unless redirect_valid; next state WAIT if ic_rwen issued, else REQ.
REQ-018 WAIT: ic_rwen=0; on ic_rdata_valid with no drop and no redirect, inst<=ic_rdata, inst_pc<=pc, pc<=pc+4 (mod 2^32), next HOLD.
REQ-019 HOLD: inst_valid=1 unless redirect_valid; handshake when inst_valid and inst_ready; after handshake next state is REQ.
REQ-020 Outside HOLD, inst_valid=0; inst/inst_pc are held stable throughout HOLD.
REQ-021 Redirect has priority over every other event; pc<={redirect_pc[31:2],2'b00} on any cycle with redirect_valid.
REQ-022 Redirect in REQ: request suppressed that cycle; state stays REQ; next cycle issues redirect target.
REQ-023 Redirect in WAIT without ic_rdata_valid: set drop flag, stay WAIT; the next response is discarded, drop cleared, next state REQ.
REQ-024 Redirect in the same cycle as ic_rdata_valid: response discarded, next state REQ, drop flag left clear.
REQ-025 Redirect in HOLD: inst_valid forced 0 that cycle (no handshake), next state REQ.
REQ-026 Back-to-back redirects: the last one wins; at most one response is ever dropped per outstanding request.
REQ-027 Hit timing: request at cycle T, cache strobe at T+2, inst_valid at T+3; with inst_ready=1 next request at T+4.
REQ-028 ic_rdata_valid arriving in REQ or HOLD is ignored.

Reset
REQ-029 During rst: pc=RESET_PC, state=REQ, drop=0, inst=0, inst_pc=0, inst_valid=0, ic_rwen=0, counters=0.
REQ-030 First cycle with rst low issues ic_rwen=1, ic_raddr=RESET_PC.
REQ-031 rst mid-WAIT abandons the request; a late ic_rdata_valid after reset release, while in REQ, is ignored per REQ-028.

Configuration
REQ-032 Macro YSYX_22051086_IFU_PERF_EN: when defined, perf_fetch_cnt increments on each decode handshake and perf_stall_cnt increments on each WAIT cycle, both wrapping at 2^32.
REQ-033 Without YSYX_22051086_IFU_PERF_EN, both counter ports are constant 0 and no counter flops exist; all other behaviour is identical.

Verification
REQ-034 Reset release, cache hit, inst_ready=1 -> ic_raddr=0x8000_0000 at cycle 0; inst_pc=0x8000_0000 valid at cycle 3; next ic_raddr=0x8000_0004 at cycle 4.
REQ-035 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, no ic_rwen; ready=1 -> one handshake, then REQ.
REQ-036 Redirect to 0x8000_0100 during WAIT -> pending response dropped, inst_valid stays 0; next ic_raddr=0x8000_0100; delivered inst_pc=0x8000_0100.
REQ-037 Redirect coincident with ic_rdata_valid; redirect to 0x8000_0203 in HOLD -> no handshake either time; next fetch at 0x8000_0200.
REQ-038 pc=0xFFFF_FFFC fetched -> next ic_raddr=0x0000_0000.
REQ-039 With YSYX_22051086_IFU_PERF_EN: 10 handshakes with 2 miss stalls of 8 cycles -> perf_fetch_cnt=10 and perf_stall_cnt equals the total WAIT cycles; without the macro both read 0.
